udm_periph_hub: RTL and testbench



---
 rtl/udm_periph_hub_pkg.sv | 25 ++
 rtl/hub_sw_debounce.sv | 51 +++++
 rtl/udm_periph_hub.sv | 166 ++++++++++++++++
 tb/tb_udm_periph_hub.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/udm_periph_hub_pkg.sv
// Shared definitions for the udm peripheral hub: register offsets, the
// unmapped read value and the Galois LFSR step.
package udm_periph_hub_pkg;

   localparam logic [31:0] REG_LED       = 32'h0000_0000;
   localparam logic [31:0] REG_SW        = 32'h0000_0004;
   localparam logic [31:0] REG_LFSR_VAL  = 32'h0000_0008;
   localparam logic [31:0] REG_LFSR_SEED = 32'h0000_000C;
   localparam logic [31:0] REG_SW_EDGE   = 32'h0000_0010;
   localparam logic [31:0] REG_ID        = 32'h0000_0014;
   localparam logic [31:0] REG_CYCLES    = 32'h0000_0018;

   localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

   function automatic logic [31:0] lfsr_step(input logic [31:0] cur, input logic [31:0] poly);
      logic [31:0] nxt;
      if (cur[0]) begin
         nxt = (cur >> 1) ^ poly;
      end else begin
         nxt = cur >> 1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/hub_sw_debounce.sv
// One-bit switch debouncer: 2-flop synchroniser, stability counter,
// debounced output and a rising pulse aligned with the output flip.
module hub_sw_debounce #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
   input  logic clk_gen,
   input  logic srst,
   input  logic sw_i,
   output logic sw_o,
   output logic rise_o
);

   logic        sync1_q, sync2_q, deb_q, deb_d, flip_s;
   logic [15:0] cnt_q, cnt_d;

   // Count consecutive disagreement; flip the output when the count completes.
   always_comb begin
      cnt_d  = cnt_q;
      deb_d  = deb_q;
      flip_s = 1'b0;
      if (sync2_q != deb_q) begin
         if ((cnt_q + 16'd1) == DEBOUNCE_CYCLES) begin
            flip_s = 1'b1;
            deb_d  = sync2_q;
            cnt_d  = 16'd0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end else begin
         cnt_d = 16'd0;
      end
   end

   always_ff @(posedge clk_gen) begin
      if (srst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sw_o   = deb_q;
   assign rise_o = flip_s & sync2_q;

endmodule

// File: rtl/udm_periph_hub.sv
// MemSplit32 peripheral slave behind the udm debug master: LEDs, debounced
// switches, LFSR, ID and test RAM. Define UDM_PERIPH_HUB_TIMER_EN for the CYCLES counter.
module udm_periph_hub
   import udm_periph_hub_pkg::*;
#(
   parameter int          LED_WIDTH         = 16,
   parameter int          SW_WIDTH          = 16,
   parameter int          TESTMEM_WSIZE_POW = 10,
   parameter logic [31:0] TESTMEM_BASE      = 32'h8000_0000,
   parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd1000,
   parameter logic [31:0] LFSR_POLY         = 32'h8020_0003,
   parameter logic [31:0] LFSR_SEED         = 32'hABCD_E123,
   parameter logic [31:0] HUB_ID            = 32'h4855_4201
) (
   input  logic                 clk_gen,
   input  logic                 srst,
   input  logic                 bus_req_i,
   input  logic                 bus_we_i,
   input  logic [31:0]          bus_addr_bi,
   input  logic [3:0]           bus_be_bi,
   input  logic [31:0]          bus_wdata_bi,
   output logic                 bus_ack_o,
   output logic                 bus_resp_o,
   output logic [31:0]          bus_rdata_bo,
   input  logic [SW_WIDTH-1:0]  sw_i,
   output logic [LED_WIDTH-1:0] led_o
);

   localparam int          MEM_DEPTH = 1 << TESTMEM_WSIZE_POW;
   localparam logic [31:0] MEM_MASK  = ~((32'd4 << TESTMEM_WSIZE_POW) - 32'd1);

   logic                         rd_s, wr_s, mem_hit_s, reg_rd_s, reg_wr_s;
   logic [TESTMEM_WSIZE_POW-1:0] mem_idx_s;
   logic [SW_WIDTH-1:0]          sw_deb_s, sw_rise_s, edge_clr_s, edge_d, edge_q;
   logic [LED_WIDTH-1:0]         led_d, led_q;
   logic [31:0]                  led_ext_s, led_new_s, sw_ext_s, edge_ext_s;
   logic [31:0]                  lfsr_d, lfsr_q, rdata_sel_s, reg_rdata_q, mem_rdata_q;
   logic                         resp_q, mem_sel_q;
   logic [31:0]                  mem_q [0:MEM_DEPTH-1];

   assign bus_ack_o = bus_req_i;
   assign rd_s      = bus_req_i & ~bus_we_i;
   assign wr_s      = bus_req_i & bus_we_i;
   assign mem_hit_s = (bus_addr_bi & MEM_MASK) == TESTMEM_BASE;
   assign mem_idx_s = bus_addr_bi[TESTMEM_WSIZE_POW+1:2];
   assign reg_rd_s  = rd_s & ~mem_hit_s;
   assign reg_wr_s  = wr_s & ~mem_hit_s;

   for (genvar g = 0; g < SW_WIDTH; g++) begin : g_deb
      hub_sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk_gen (clk_gen),
         .srst    (srst),
         .sw_i    (sw_i[g]),
         .sw_o    (sw_deb_s[g]),
         .rise_o  (sw_rise_s[g])
      );
   end

`ifdef UDM_PERIPH_HUB_TIMER_EN
   logic [31:0] cycles_q;

   always_ff @(posedge clk_gen) begin
      if (srst) begin
         cycles_q <= 32'd0;
      end else if (reg_wr_s && (bus_addr_bi == REG_CYCLES)) begin
         cycles_q <= 32'd0;
      end else begin
         cycles_q <= cycles_q + 32'd1;
      end
   end
`endif

   // Register next-state: byte-merged LED, LFSR seed/step, rw1c edge flags (set wins).
   always_comb begin
      led_ext_s                  = 32'd0;
      led_ext_s[LED_WIDTH-1:0]   = led_q;
      sw_ext_s                   = 32'd0;
      sw_ext_s[SW_WIDTH-1:0]     = sw_deb_s;
      edge_ext_s                 = 32'd0;
      edge_ext_s[SW_WIDTH-1:0]   = edge_q;
      led_new_s                  = led_ext_s;
      for (int b = 0; b < 4; b++) begin
         if (bus_be_bi[b]) begin
            led_new_s[8*b +: 8] = bus_wdata_bi[8*b +: 8];
         end else begin
            led_new_s[8*b +: 8] = led_ext_s[8*b +: 8];
         end
      end
      if (reg_wr_s && (bus_addr_bi == REG_LED)) begin
         led_d = led_new_s[LED_WIDTH-1:0];
      end else begin
         led_d = led_q;
      end
      if (reg_wr_s && (bus_addr_bi == REG_LFSR_SEED)) begin
         lfsr_d = (bus_wdata_bi == 32'd0) ? LFSR_SEED : bus_wdata_bi;
      end else if (reg_rd_s && (bus_addr_bi == REG_LFSR_VAL)) begin
         lfsr_d = lfsr_step(lfsr_q, LFSR_POLY);
      end else begin
         lfsr_d = lfsr_q;
      end
      if (reg_wr_s && (bus_addr_bi == REG_SW_EDGE)) begin
         edge_clr_s = bus_wdata_bi[SW_WIDTH-1:0];
      end else begin
         edge_clr_s = {SW_WIDTH{1'b0}};
      end
      edge_d = (edge_q & ~edge_clr_s) | sw_rise_s;
   end

   // Register read mux.
   always_comb begin
      rdata_sel_s = UNMAPPED_RDATA;
      if (mem_hit_s) begin
         rdata_sel_s = UNMAPPED_RDATA;
      end else begin
         case (bus_addr_bi)
            REG_LED:       rdata_sel_s = led_ext_s;
            REG_SW:        rdata_sel_s = sw_ext_s;
            REG_LFSR_VAL:  rdata_sel_s = lfsr_q;
            REG_LFSR_SEED: rdata_sel_s = 32'd0;
            REG_SW_EDGE:   rdata_sel_s = edge_ext_s;
            REG_ID:        rdata_sel_s = HUB_ID;
`ifdef UDM_PERIPH_HUB_TIMER_EN
            REG_CYCLES:    rdata_sel_s = cycles_q;
`endif
            default:       rdata_sel_s = UNMAPPED_RDATA;
         endcase
      end
   end

   always_ff @(posedge clk_gen) begin
      if (srst) begin
         led_q       <= {LED_WIDTH{1'b1}};
         lfsr_q      <= LFSR_SEED;
         edge_q      <= {SW_WIDTH{1'b0}};
         resp_q      <= 1'b0;
         mem_sel_q   <= 1'b0;
         reg_rdata_q <= 32'd0;
      end else begin
         led_q       <= led_d;
         lfsr_q      <= lfsr_d;
         edge_q      <= edge_d;
         resp_q      <= rd_s;
         mem_sel_q   <= rd_s & mem_hit_s;
         reg_rdata_q <= rd_s ? rdata_sel_s : 32'd0;
      end
   end

   // Byte-enabled single-port test RAM with registered read; contents survive reset.
   always_ff @(posedge clk_gen) begin
      if (wr_s && mem_hit_s) begin
         for (int b = 0; b < 4; b++) begin
            if (bus_be_bi[b]) begin
               mem_q[mem_idx_s][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
            end
         end
      end
      if (rd_s && mem_hit_s) begin
         mem_rdata_q <= mem_q[mem_idx_s];
      end
   end

   assign bus_resp_o   = resp_q;
   assign bus_rdata_bo = resp_q ? (mem_sel_q ? mem_rdata_q : reg_rdata_q) : 32'd0;
   assign led_o        = led_q;

endmodule

// File: tb/tb_udm_periph_hub.sv
// Directed self-checking bench for udm_periph_hub (DEBOUNCE_CYCLES=4);
// timer checks follow UDM_PERIPH_HUB_TIMER_EN.
module tb_udm_periph_hub;

   localparam logic [31:0] MBASE = 32'h8000_0000;

   logic        clk_gen = 1'b0;
   logic        srst;
   logic        bus_req_i, bus_we_i;
   logic [31:0] bus_addr_bi, bus_wdata_bi;
   logic [3:0]  bus_be_bi;
   logic        bus_ack_o, bus_resp_o;
   logic [31:0] bus_rdata_bo;
   logic [15:0] sw_i, led_o;
   int          n_total = 0;
   int          n_bad   = 0;
   logic [31:0] t0, t1;

   udm_periph_hub #(.DEBOUNCE_CYCLES(16'd4)) dut (
      .clk_gen      (clk_gen),
      .srst         (srst),
      .bus_req_i    (bus_req_i),
      .bus_we_i     (bus_we_i),
      .bus_addr_bi  (bus_addr_bi),
      .bus_be_bi    (bus_be_bi),
      .bus_wdata_bi (bus_wdata_bi),
      .bus_ack_o    (bus_ack_o),
      .bus_resp_o   (bus_resp_o),
      .bus_rdata_bo (bus_rdata_bo),
      .sw_i         (sw_i),
      .led_o        (led_o)
   );

   always #5 clk_gen = ~clk_gen;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic rd_get(input string tag, input logic [31:0] a, output logic [31:0] d);
      @(negedge clk_gen);
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = a;
      #1 check_val({tag, "_ack"}, {31'd0, bus_ack_o}, 32'd1);
      @(negedge clk_gen);
      bus_req_i = 1'b0;
      check_val({tag, "_resp"}, {31'd0, bus_resp_o}, 32'd1);
      d = bus_rdata_bo;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd_get(tag, a, d);
      check_val(tag, d, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk_gen);
      bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = a; bus_wdata_bi = d; bus_be_bi = be;
      @(negedge clk_gen);
      bus_req_i = 1'b0; bus_we_i = 1'b0;
      check_val("wr_noresp", {31'd0, bus_resp_o}, 32'd0);
   endtask

   initial begin
      srst = 1'b1; bus_req_i = 1'b0; bus_we_i = 1'b0; bus_addr_bi = 32'd0;
      bus_wdata_bi = 32'd0; bus_be_bi = 4'd0; sw_i = 16'd0;
      repeat (3) @(negedge clk_gen);
      check_val("rst_resp", {31'd0, bus_resp_o}, 32'd0);
      check_val("rst_rdata", bus_rdata_bo, 32'd0);
      check_val("rst_led", {16'd0, led_o}, 32'h0000_FFFF);
      srst = 1'b0;

      rd_chk("led_rst", 32'h00, 32'h0000_FFFF);
      rd_chk("id", 32'h14, 32'h4855_4201);
      wr(32'h00, 32'h1234_5678, 4'b0010);
      rd_chk("led_be", 32'h00, 32'h0000_56FF);
      check_val("led_port", {16'd0, led_o}, 32'h0000_56FF);
      wr(32'h00, 32'hFFFF_0000, 4'b1111);
      rd_chk("led_upper", 32'h00, 32'h0000_0000);

      // Back-to-back LFSR reads: seed, then two Galois steps.
      @(negedge clk_gen);
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = 32'h08;
      @(negedge clk_gen);
      check_val("lfsr0", bus_rdata_bo, 32'hABCD_E123);
      @(negedge clk_gen);
      check_val("lfsr1", bus_rdata_bo, 32'hD5C6_F092);
      @(negedge clk_gen);
      bus_req_i = 1'b0;
      check_val("lfsr2", bus_rdata_bo, 32'h6AE3_7849);
      check_val("lfsr2_resp", {31'd0, bus_resp_o}, 32'd1);
      @(negedge clk_gen);
      check_val("resp_pulse_end", {31'd0, bus_resp_o}, 32'd0);
      check_val("rdata_idle", bus_rdata_bo, 32'd0);
      wr(32'h0C, 32'h0000_0001, 4'b0000);
      rd_chk("lfsr_seed1", 32'h08, 32'h0000_0001);
      rd_chk("lfsr_seed1_step", 32'h08, 32'h8020_0003);
      wr(32'h0C, 32'h0000_0000, 4'b1111);
      rd_chk("lfsr_seed0", 32'h08, 32'hABCD_E123);

      // Switch glitch of 2 cycles must not pass.
      @(negedge clk_gen); sw_i[3] = 1'b1;
      repeat (2) @(negedge clk_gen);
      sw_i[3] = 1'b0;
      repeat (8) @(negedge clk_gen);
      rd_chk("sw_glitch", 32'h04, 32'h0000_0000);
      rd_chk("edge_glitch", 32'h10, 32'h0000_0000);
      // Stable high: output flips on the 6th edge after the change.
      @(negedge clk_gen); sw_i[3] = 1'b1;
      repeat (4) @(negedge clk_gen);
      rd_chk("sw_early", 32'h04, 32'h0000_0000);
      rd_chk("sw_set", 32'h04, 32'h0000_0008);
      rd_chk("edge_set", 32'h10, 32'h0000_0008);
      wr(32'h10, 32'h0000_0008, 4'b1111);
      rd_chk("edge_clr", 32'h10, 32'h0000_0000);
      rd_chk("sw_hold", 32'h04, 32'h0000_0008);

      wr(MBASE + 32'hFFC, 32'h1122_3344, 4'b1111);
      wr(MBASE + 32'hFFC, 32'hA5A5_A5A5, 4'b1001);
      rd_chk("mem_be", MBASE + 32'hFFC, 32'hA522_33A5);
      wr(MBASE, 32'hCAFE_F00D, 4'b1111);
      rd_chk("mem_base", MBASE, 32'hCAFE_F00D);
      rd_chk("mem_top_keep", MBASE + 32'hFFC, 32'hA522_33A5);
      rd_chk("mem_past_end", MBASE + 32'h1000, 32'hDEAD_BEEF);
      wr(32'h14, 32'h0000_0000, 4'b1111);
      rd_chk("id_ro", 32'h14, 32'h4855_4201);
      rd_chk("unmapped", 32'h1C, 32'hDEAD_BEEF);

`ifdef UDM_PERIPH_HUB_TIMER_EN
      rd_get("cyc_a", 32'h18, t0);
      repeat (8) @(negedge clk_gen);
      rd_get("cyc_b", 32'h18, t1);
      check_val("cyc_delta", t1 - t0, 32'd10);
      wr(32'h18, 32'h1234_5678, 4'b1111);
      rd_chk("cyc_clear", 32'h18, 32'd1);
`else
      t0 = 32'd0; t1 = 32'd0;
      rd_chk("cyc_unmapped", 32'h18, 32'hDEAD_BEEF);
`endif

      // Reset in the cycle after a read, then reset coinciding with a read.
      @(negedge clk_gen);
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = 32'h14;
      @(negedge clk_gen);
      bus_req_i = 1'b0; srst = 1'b1;
      @(negedge clk_gen);
      srst = 1'b0;
      check_val("srst_after_resp", {31'd0, bus_resp_o}, 32'd0);
      check_val("srst_led", {16'd0, led_o}, 32'h0000_FFFF);
      @(negedge clk_gen);
      bus_req_i = 1'b1; bus_addr_bi = 32'h14; srst = 1'b1;
      @(negedge clk_gen);
      bus_req_i = 1'b0; srst = 1'b0;
      check_val("srst_drop_resp", {31'd0, bus_resp_o}, 32'd0);
      check_val("srst_drop_rdata", bus_rdata_bo, 32'd0);
      rd_chk("lfsr_after_rst", 32'h08, 32'hABCD_E123);
      rd_chk("edge_after_rst", 32'h10, 32'h0000_0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
